decode_out_capture: RTL and testbench

Parametrised capture buffer for LC3 decode-stage outputs. Samples the decode output bundle (e/m/w control, IR, NPC) on every cycle with en_de_s high and queues it as a packed record. Records drain to a scoreboard/monitor through a valid/ready port, so bursts are not lost when the consumer stalls. Successor to the fixed-width decode-output monitor hookup: adds configurable field widths, buffer depth, overflow accounting and optional timestamping.

---
 rtl/decode_out_capture_pkg.sv | 46 ++++
 rtl/decode_cap_fifo.sv | 75 +++++++
 rtl/decode_out_capture.sv | 115 +++++++++++
 tb/tb_decode_out_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_out_capture_pkg.sv
// Shared definitions for the LC3 decode-output capture buffer.
// Optional feature macro: DECODE_CAP_TSTAMP_EN (appends a timestamp at the record MSBs).
package decode_out_capture_pkg;

  // Default field widths of the decode output bundle
  localparam int unsigned E_W_DEF   = 6;
  localparam int unsigned M_W_DEF   = 1;
  localparam int unsigned W_W_DEF   = 2;
  localparam int unsigned IW_DEF    = 16;
  localparam int unsigned AW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned TS_W_DEF  = 32;

`ifdef DECODE_CAP_TSTAMP_EN
  localparam int unsigned TS_BITS_DEF = TS_W_DEF;
`else
  localparam int unsigned TS_BITS_DEF = 0;
`endif

  localparam int unsigned REC_W_DEF =
    AW_DEF + IW_DEF + W_W_DEF + M_W_DEF + E_W_DEF + TS_BITS_DEF;

  // Record layout at default widths; first member sits at the MSBs
  typedef struct packed {
`ifdef DECODE_CAP_TSTAMP_EN
    logic [TS_W_DEF-1:0] ts;
`endif
    logic [AW_DEF-1:0]   npc;
    logic [IW_DEF-1:0]   ir;
    logic [W_W_DEF-1:0]  w;
    logic [M_W_DEF-1:0]  m;
    logic [E_W_DEF-1:0]  e;
  } dec_rec_t;

  // Flatten a record into the bus word carried on rec_data_o
  function automatic logic [REC_W_DEF-1:0] pack_rec(input dec_rec_t r);
    return REC_W_DEF'(r);
  endfunction

  // Split a rec_data_o word back into its fields
  function automatic dec_rec_t unpack_rec(input logic [REC_W_DEF-1:0] v);
    return dec_rec_t'(v);
  endfunction

endpackage

// File: rtl/decode_cap_fifo.sv
// Generic synchronous FIFO with occupancy output; full/empty derive from level.
module decode_cap_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_empty_c,
  output logic             o_full_c,
  output logic [LVL_W-1:0] o_level
);

  // Elaboration-time sanity check on depth
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_cap_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty_c = (r_level == '0);
  assign o_full_c  = (r_level == LVL_W'(DEPTH));
  assign o_level   = r_level;

  // Clear wins over both ports; a push into a full FIFO needs a same-cycle pop
  assign w_pop  = i_pop & ~o_empty_c & ~i_clear;
  assign w_push = i_push & (~o_full_c | w_pop) & ~i_clear;

  // Head is forced to zero while empty so stale entries never leak out
  assign o_rdata_c = o_empty_c ? '0 : r_mem[r_rd_ptr];

  // Storage array, no reset needed since level gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decode_out_capture.sv
// Capture buffer for LC3 decode-stage outputs: qualifies captures with en_de_s,
// packs e/m/w/IR/NPC into a record, queues it and drains it over valid/ready,
// counting samples lost while the buffer is full.
// Optional feature macro: DECODE_CAP_TSTAMP_EN (free-running timestamp at record MSBs).
module decode_out_capture
  import decode_out_capture_pkg::*;
#(
  parameter int unsigned E_W   = E_W_DEF,
  parameter int unsigned M_W   = M_W_DEF,
  parameter int unsigned W_W   = W_W_DEF,
  parameter int unsigned IW    = IW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF,
`ifdef DECODE_CAP_TSTAMP_EN
  localparam int unsigned TS_BITS = TS_W,
`else
  localparam int unsigned TS_BITS = 0,
`endif
  localparam int unsigned REC_W = AW + IW + W_W + M_W + E_W + TS_BITS,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock_s,
  input  logic             reset_s,
  input  logic             en_de_s,
  input  logic [E_W-1:0]   e_cntrl_s,
  input  logic [M_W-1:0]   m_cntrl_s,
  input  logic [W_W-1:0]   w_cntrl_s,
  input  logic [IW-1:0]    Instr_Reg_s,
  input  logic [AW-1:0]    npc_out_s,
  input  logic             clear_i,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [REC_W-1:0] rec_data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  // Elaboration-time sanity check on counter widths
  if (TS_W == 0 || CNT_W == 0) begin : g_bad_width
    $error("decode_out_capture: TS_W and CNT_W must be nonzero");
  end

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

`ifdef DECODE_CAP_TSTAMP_EN
  logic [TS_W-1:0]  r_ts;

  // Free-running timestamp; wraps, untouched by clear_i
  always_ff @(posedge clock_s or posedge reset_s) begin
    if (reset_s) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Record packing, LSB first: e, m, w, IR, NPC, timestamp
  assign w_rec = {r_ts, npc_out_s, Instr_Reg_s, w_cntrl_s, m_cntrl_s, e_cntrl_s};
`else
  // Record packing, LSB first: e, m, w, IR, NPC
  assign w_rec = {npc_out_s, Instr_Reg_s, w_cntrl_s, m_cntrl_s, e_cntrl_s};
`endif

  // Capture qualification; a full buffer still accepts when the head leaves this cycle
  assign rec_valid_o = ~w_empty;
  assign w_pop       = rec_valid_o & rec_ready_i;
  assign w_push      = en_de_s & (~w_full | w_pop);
  assign w_drop      = en_de_s & w_full & ~w_pop & ~clear_i;

  decode_cap_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock_s),
    .rst       (reset_s),
    .i_clear   (clear_i),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_rec),
    .o_rdata_c (rec_data_o),
    .o_empty_c (w_empty),
    .o_full_c  (w_full),
    .o_level   (level_o)
  );

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clock_s or posedge reset_s) begin
    if (reset_s) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_decode_out_capture.sv
// Self-checking bench for decode_out_capture at default parameters.
module tb_decode_out_capture;
  import decode_out_capture_pkg::*;

  localparam int unsigned REC_W = REC_W_DEF;
  localparam int unsigned LVL_W = $clog2(DEPTH_DEF) + 1;
  localparam int unsigned DEPTH = DEPTH_DEF;

  logic               clock_s = 1'b0;
  logic               reset_s;
  logic               en_de_s;
  logic [E_W_DEF-1:0] e_cntrl_s;
  logic [M_W_DEF-1:0] m_cntrl_s;
  logic [W_W_DEF-1:0] w_cntrl_s;
  logic [IW_DEF-1:0]  Instr_Reg_s;
  logic [AW_DEF-1:0]  npc_out_s;
  logic               clear_i;
  logic               rec_valid_o;
  logic               rec_ready_i;
  logic [REC_W-1:0]   rec_data_o;
  logic [LVL_W-1:0]   level_o;
  logic               overflow_o;
  logic [CNT_W_DEF-1:0] drop_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  decode_out_capture dut (
    .clock_s     (clock_s),
    .reset_s     (reset_s),
    .en_de_s     (en_de_s),
    .e_cntrl_s   (e_cntrl_s),
    .m_cntrl_s   (m_cntrl_s),
    .w_cntrl_s   (w_cntrl_s),
    .Instr_Reg_s (Instr_Reg_s),
    .npc_out_s   (npc_out_s),
    .clear_i     (clear_i),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .rec_data_o  (rec_data_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clock_s = ~clock_s;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        clr;
    logic [15:0] ir;
    logic        valid;
    int unsigned lvl;
    logic [15:0] head;
    logic        ovf;
    int unsigned drop;
  } vec_t;

  vec_t tbl[$];
  logic [REC_W-1:0] q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected record for a capture whose payload is derived from ir (timestamp zero)
  function automatic logic [REC_W-1:0] mk_rec(input logic [15:0] ir);
    dec_rec_t r;
    r     = '0;
    r.e   = ir[5:0] ^ 6'h2A;
    r.m   = ir[0];
    r.w   = ir[2:1];
    r.ir  = ir;
    r.npc = ir ^ 16'h3000;
    return pack_rec(r);
  endfunction

  // Strip the timestamp so records compare on payload only
  function automatic logic [REC_W-1:0] core(input logic [REC_W-1:0] v);
    dec_rec_t r;
    r = unpack_rec(v);
`ifdef DECODE_CAP_TSTAMP_EN
    r.ts = '0;
`endif
    return pack_rec(r);
  endfunction

  task automatic set_in(input logic [15:0] ir, input logic en, input logic rdy, input logic clr);
    en_de_s     = en;
    rec_ready_i = rdy;
    clear_i     = clr;
    Instr_Reg_s = ir;
    e_cntrl_s   = ir[5:0] ^ 6'h2A;
    m_cntrl_s   = ir[0];
    w_cntrl_s   = ir[2:1];
    npc_out_s   = ir ^ 16'h3000;
  endtask

  task automatic step();
    @(posedge clock_s);
    #1;
  endtask

  task automatic add(input logic en, input logic rdy, input logic clr, input logic [15:0] ir,
                     input logic valid, input int unsigned lvl, input logic [15:0] head,
                     input logic ovf, input int unsigned drop);
    vec_t v;
    v.en = en; v.rdy = rdy; v.clr = clr; v.ir = ir; v.valid = valid;
    v.lvl = lvl; v.head = head; v.ovf = ovf; v.drop = drop;
    tbl.push_back(v);
  endtask

  initial begin
    dec_rec_t    r1;
    logic        en_b, rdy_b, pop_m, push_m, ovf_m;
    logic [15:0] ir_b;
    int unsigned drop_m;

    reset_s = 1'b1;
    set_in(16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock_s);
    #1;
    chk("rst_valid", 128'(rec_valid_o), 128'(0));
    chk("rst_data",  128'(rec_data_o),  128'(0));
    chk("rst_level", 128'(level_o),     128'(0));
    chk("rst_ovf",   128'(overflow_o),  128'(0));
    chk("rst_drop",  128'(drop_cnt_o),  128'(0));
    @(negedge clock_s);
    reset_s = 1'b0;
    step();

    // Single capture with the documented field values
    en_de_s = 1'b1; rec_ready_i = 1'b0; clear_i = 1'b0;
    Instr_Reg_s = 16'h1283; npc_out_s = 16'h3001;
    e_cntrl_s = 6'h21; m_cntrl_s = 1'b0; w_cntrl_s = 2'b10;
    step();
    r1 = '0;
    r1.e = 6'h21; r1.m = 1'b0; r1.w = 2'b10; r1.ir = 16'h1283; r1.npc = 16'h3001;
    set_in(16'h0, 1'b0, 1'b0, 1'b0);
    chk("single_valid", 128'(rec_valid_o),      128'(1));
    chk("single_data",  128'(core(rec_data_o)), 128'(pack_rec(r1)));
    chk("single_level", 128'(level_o),          128'(1));
    step();
    chk("single_hold",  128'(core(rec_data_o)), 128'(pack_rec(r1)));
    set_in(16'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk("single_pop_valid", 128'(rec_valid_o), 128'(0));
    chk("single_pop_data",  128'(rec_data_o),  128'(0));
    chk("single_pop_level", 128'(level_o),     128'(0));

    // Burst of 8, overflow, full push+pop, drain, clear, no-bypass
    for (int k = 0; k < 8; k++) add(1, 0, 0, 16'(k), 1, k + 1, 16'h0, 0, 0);
    add(1, 0, 0, 16'h10, 1, 8, 16'h0, 1, 1);
    add(1, 0, 0, 16'h11, 1, 8, 16'h0, 1, 2);
    add(1, 0, 0, 16'h12, 1, 8, 16'h0, 1, 3);
    add(1, 1, 0, 16'h20, 1, 8, 16'h1, 1, 3);
    for (int k = 0; k < 6; k++) add(0, 1, 0, 16'h0, 1, 7 - k, 16'(k + 2), 1, 3);
    add(0, 1, 0, 16'h0, 1, 1, 16'h20, 1, 3);
    add(0, 1, 0, 16'h0, 0, 0, 16'h0,  1, 3);
    add(1, 0, 0, 16'h30, 1, 1, 16'h30, 1, 3);
    add(1, 0, 0, 16'h31, 1, 2, 16'h30, 1, 3);
    add(1, 1, 1, 16'h32, 0, 0, 16'h0,  0, 0);
    add(1, 1, 0, 16'h40, 1, 1, 16'h40, 0, 0);
    add(1, 1, 0, 16'h41, 1, 1, 16'h41, 0, 0);
    add(0, 1, 0, 16'h0,  0, 0, 16'h0,  0, 0);

    foreach (tbl[i]) begin
      set_in(tbl[i].ir, tbl[i].en, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("vec%0d_valid", i), 128'(rec_valid_o), 128'(tbl[i].valid));
      chk($sformatf("vec%0d_level", i), 128'(level_o),     128'(tbl[i].lvl));
      chk($sformatf("vec%0d_data", i),  128'(core(rec_data_o)),
          tbl[i].valid ? 128'(mk_rec(tbl[i].head)) : 128'(0));
      chk($sformatf("vec%0d_ovf", i),   128'(overflow_o),  128'(tbl[i].ovf));
      chk($sformatf("vec%0d_drop", i),  128'(drop_cnt_o),  128'(tbl[i].drop));
    end
    set_in(16'h0, 1'b0, 1'b0, 1'b0);

    // Random backpressure against a queue model
    ovf_m  = 1'b0;
    drop_m = 0;
    for (int c = 0; c < 160; c++) begin
      chk("bp_valid", 128'(rec_valid_o), 128'(q.size() != 0));
      chk("bp_level", 128'(level_o),     128'(q.size()));
      if (q.size() != 0) chk("bp_data", 128'(core(rec_data_o)), 128'(q[0]));
      else               chk("bp_data", 128'(rec_data_o), 128'(0));
      en_b  = ($urandom_range(0, 3) != 0);
      rdy_b = 1'($urandom_range(0, 1));
      ir_b  = 16'h100 + 16'(c);
      set_in(ir_b, en_b, rdy_b, 1'b0);
      pop_m  = (q.size() != 0) && rdy_b;
      push_m = en_b && ((q.size() < DEPTH) || pop_m);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(mk_rec(ir_b));
      else if (en_b) begin
        ovf_m  = 1'b1;
        drop_m = drop_m + 1;
      end
      step();
    end
    chk("bp_ovf",  128'(overflow_o), 128'(ovf_m));
    chk("bp_drop", 128'(drop_cnt_o), 128'(drop_m));

    // Async reset mid-burst
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      set_in(16'h60 + 16'(k), 1'b1, 1'b0, 1'b0);
      step();
    end
    set_in(16'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_level5", 128'(level_o), 128'(5));
    #2;
    reset_s = 1'b1;
    #1;
    chk("arst_valid", 128'(rec_valid_o), 128'(0));
    chk("arst_data",  128'(rec_data_o),  128'(0));
    chk("arst_level", 128'(level_o),     128'(0));
    @(posedge clock_s);
    @(negedge clock_s);
    reset_s = 1'b0;
    step();
    chk("post_rel_valid", 128'(rec_valid_o), 128'(0));
    step();
    set_in(16'h50, 1'b1, 1'b0, 1'b0);
    step();
    set_in(16'h0, 1'b0, 1'b0, 1'b0);
    chk("post_rel_cap_level", 128'(level_o),          128'(1));
    chk("post_rel_cap_data",  128'(core(rec_data_o)), 128'(mk_rec(16'h50)));
`ifdef DECODE_CAP_TSTAMP_EN
    r1 = unpack_rec(rec_data_o);
    chk("post_rel_ts", 128'(r1.ts), 128'(2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
